// File: rtl/clock_divider.sv
// Programmable periodic timer: emits a one-clock clk_out pulse every
// count x 2^(STEP*sel) clocks after a configuring enable strobe.
module clock_divider #(
    parameter int STEP  = 2,
    parameter int PRE_W = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] sel,
    input  logic [5:0] count,
    output logic       clk_out
);

    logic [2:0]       r_sel;
    logic [5:0]       r_count;
    logic [PRE_W-1:0] r_pre;
    logic [5:0]       r_tick;
    logic             r_out;

    logic [PRE_W-1:0] w_mask;
    logic             w_wrap;
    logic             w_run;
    logic             w_expire;
    logic [5:0]       w_tick_nx;

    // Prescaler terminal value is D-1, i.e. the low STEP*sel bits all set.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PRE_W; i++) begin
            w_mask[i] = (i < STEP * int'(r_sel));
        end
    end

    assign w_wrap    = (r_pre == w_mask);
    assign w_run     = (r_count != 6'd0);
    assign w_tick_nx = r_tick + 6'd1;
    assign w_expire  = w_run && w_wrap && (w_tick_nx == r_count);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel   <= '0;
            r_count <= '0;
            r_pre   <= '0;
            r_tick  <= '0;
            r_out   <= 1'b0;
        end else if (enable) begin
            r_sel   <= sel;
            r_count <= count;
            r_pre   <= '0;
            r_tick  <= '0;
            r_out   <= 1'b0;
        end else if (w_run) begin
            r_out <= w_expire;
            if (w_wrap) begin
                r_pre  <= '0;
                r_tick <= w_expire ? 6'd0 : w_tick_nx;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end else begin
            r_out <= 1'b0;
        end
    end

    assign clk_out = r_out;

endmodule

// File: tb/tb_clock_divider.sv
// Directed table-driven bench for clock_divider plus hand-written
// sequences for reconfiguration, stop, enable-on-expiry and async reset.
module tb_clock_divider;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [2:0] sel;
    logic [5:0] count;
    logic       clk_out;

    int total;
    int bad;

    clock_divider #(.STEP(2), .PRE_W(14)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .sel     (sel),
        .count   (count),
        .clk_out (clk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic [5:0] cnt;
        int         per;
        int         span;
        int         npulse;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic configure(input logic [2:0] s, input logic [5:0] c);
        @(negedge clk);
        enable = 1'b1;
        sel    = s;
        count  = c;
        @(posedge clk);
        #1;
        enable = 1'b0;
        sel    = 3'd5;
        count  = 6'd33;
    endtask

    task automatic run_quiet(input string name, input int n);
        int pulses;
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (clk_out) pulses++;
        end
        chk(name, pulses, 0);
    endtask

    initial begin
        tbl[0] = '{3'd0, 6'd4,  4,     12,    3};
        tbl[1] = '{3'd1, 6'd3,  12,    40,    3};
        tbl[2] = '{3'd0, 6'd1,  1,     5,     5};
        tbl[3] = '{3'd2, 6'd2,  32,    70,    2};
        tbl[4] = '{3'd0, 6'd63, 63,    130,   2};
        tbl[5] = '{3'd3, 6'd1,  64,    130,   2};
        tbl[6] = '{3'd7, 6'd1,  16384, 16390, 1};

        total  = 0;
        bad    = 0;
        reset  = 1'b0;
        enable = 1'b1;
        sel    = 3'd3;
        count  = 6'd5;

        repeat (5) @(posedge clk);
        #1;
        chk("reset_out", clk_out, 0);
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b1;
        run_quiet("post_reset_idle", 10000);

        foreach (tbl[v]) begin
            int pulses;
            int errs;
            pulses = 0;
            errs   = 0;
            configure(tbl[v].sel, tbl[v].cnt);
            for (int k = 1; k <= tbl[v].span; k++) begin
                @(posedge clk);
                #1;
                if (clk_out) pulses++;
                if (clk_out !== ((k % tbl[v].per) == 0)) begin
                    errs++;
                    if (errs <= 4)
                        $display("FAIL vec%0d edge%0d: got %0b expected %0b",
                                 v, k, clk_out, (k % tbl[v].per) == 0);
                end
            end
            chk($sformatf("vec%0d_edges", v), errs, 0);
            chk($sformatf("vec%0d_pulses", v), pulses, tbl[v].npulse);
        end

        // Mid-period reconfigure: old period 10, new period 2.
        configure(3'd0, 6'd10);
        run_quiet("reconf_pre", 6);
        configure(3'd0, 6'd2);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("reconf_e%0d", k), clk_out, (k % 2) == 0);
        end

        // Stop by writing count=0.
        configure(3'd0, 6'd5);
        repeat (2) @(posedge clk);
        configure(3'd0, 6'd0);
        run_quiet("stopped", 1000);

        // Enable on the expiry edge suppresses the pulse and restarts.
        configure(3'd0, 6'd5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        enable = 1'b1;
        sel    = 3'd0;
        count  = 6'd5;
        @(posedge clk);
        #1;
        chk("enable_on_expiry", clk_out, 0);
        enable = 1'b0;
        run_quiet("restart_gap", 4);
        @(posedge clk);
        #1;
        chk("restart_pulse", clk_out, 1);

        // Asynchronous reset between edges.
        configure(3'd0, 6'd3);
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_async_pulse", clk_out, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_drop", clk_out, 0);
        @(negedge clk);
        reset = 1'b1;
        run_quiet("post_async_idle", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
